// File: rtl/data_memory_ctrl.sv
// Handshaked word-organised data memory with configurable access latency,
// sub-word stores, sign/zero-extending loads and access error reporting.
module data_memory_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 128,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int                    IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-2:0] DEPTH_W = (ADDR_WIDTH-1)'(DEPTH);
    localparam logic [3:0]            LAT_M1  = 4'(LATENCY - 1);

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic                  write_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  resp_valid_q;
    logic [31:0]           rdata_q;
    logic                  error_q;
    logic [31:0]           mem_q [DEPTH];

    logic                  acc_write_s;
    logic [1:0]            acc_size_s;
    logic                  acc_uns_s;
    logic [ADDR_WIDTH-1:0] acc_addr_s;
    logic [31:0]           acc_wdata_s;
    logic [ADDR_WIDTH-3:0] word_idx_s;
    logic [31:0]           rd_word_s;
    logic [7:0]            byte_s;
    logic [15:0]           half_s;
    logic [31:0]           load_s;
    logic                  do_access_s;
    logic                  error_d;
    logic [31:0]           rdata_d;
    logic [31:0]           wword_d;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;

    // With LATENCY==1 the access happens on the accept edge, so the live request is used.
    always_comb begin
        if (state_q == IDLE) begin
            acc_write_s = req_write;
            acc_size_s  = req_size;
            acc_uns_s   = req_unsigned;
            acc_addr_s  = req_addr;
            acc_wdata_s = req_wdata;
        end else begin
            acc_write_s = write_q;
            acc_size_s  = size_q;
            acc_uns_s   = uns_q;
            acc_addr_s  = addr_q;
            acc_wdata_s = wdata_q;
        end
        word_idx_s = acc_addr_s[ADDR_WIDTH-1:2];
        rd_word_s  = mem_q[word_idx_s[IW-1:0]];
        case (acc_addr_s[1:0])
            2'b00:   byte_s = rd_word_s[7:0];
            2'b01:   byte_s = rd_word_s[15:8];
            2'b10:   byte_s = rd_word_s[23:16];
            default: byte_s = rd_word_s[31:24];
        endcase
        half_s  = acc_addr_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];
        wword_d = rd_word_s;
        load_s  = rd_word_s;
        case (acc_size_s)
            2'b00: begin
                error_d = (acc_addr_s[1:0] != 2'b00);
                wword_d = acc_wdata_s;
            end
            2'b10: begin
                error_d = acc_addr_s[0];
                load_s  = {{16{half_s[15] & ~acc_uns_s}}, half_s};
                if (acc_addr_s[1]) begin
                    wword_d[31:16] = acc_wdata_s[15:0];
                end else begin
                    wword_d[15:0] = acc_wdata_s[15:0];
                end
            end
            2'b11: begin
                error_d = 1'b0;
                load_s  = {{24{byte_s[7] & ~acc_uns_s}}, byte_s};
                case (acc_addr_s[1:0])
                    2'b00:   wword_d[7:0]   = acc_wdata_s[7:0];
                    2'b01:   wword_d[15:8]  = acc_wdata_s[7:0];
                    2'b10:   wword_d[23:16] = acc_wdata_s[7:0];
                    default: wword_d[31:24] = acc_wdata_s[7:0];
                endcase
            end
            default: error_d = 1'b1;
        endcase
        if ({1'b0, word_idx_s} >= DEPTH_W) begin
            error_d = 1'b1;
        end else begin
            error_d = error_d;
        end
        rdata_d = (error_d || acc_write_s) ? 32'h0000_0000 : load_s;
    end

    assign do_access_s = !rst &&
                         (((state_q == IDLE) && req_valid && (LATENCY == 1)) ||
                          ((state_q == WAIT) && (cnt_q <= 4'd1)));

    // Storage array: no reset, written only by a successful store on its access edge.
    always_ff @(posedge clk) begin
        if (do_access_s && acc_write_s && !error_d) begin
            mem_q[word_idx_s[IW-1:0]] <= wword_d;
        end
    end

    // Request/response FSM with registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            error_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= LAT_M1;
                        if (LATENCY == 1) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            rdata_q      <= rdata_d;
                            error_q      <= error_d;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        cnt_q        <= 4'd0;
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        rdata_q      <= rdata_d;
                        error_q      <= error_d;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        rdata_q      <= 32'h0000_0000;
                        error_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: a LATENCY=3/DEPTH=128 instance and a
// LATENCY=1/DEPTH=64 instance sharing request payload signals.
module tb_data_memory_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid2;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;
    logic        req_ready, resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic        req_ready2, resp_valid2, resp_error2;
    logic [31:0] resp_rdata2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.ADDR_WIDTH(9), .DEPTH(128), .LATENCY(3)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    data_memory_ctrl #(.ADDR_WIDTH(9), .DEPTH(64), .LATENCY(1)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid2),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata2), .resp_error(resp_error2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction; called #1 after a posedge with the DUT idle.
    task automatic do_req(input bit sel, input logic wr, input logic [1:0] sz, input logic un,
                          input logic [11:0] a, input logic [31:0] wd, input int exp_lat,
                          input logic [31:0] exp_data, input logic exp_err, input int hold,
                          input string tag);
        int          cyc;
        logic [31:0] rd;
        logic        er;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = un;
        req_addr     = a[8:0];
        req_wdata    = wd;
        resp_ready   = (hold == 0);
        if (sel) req_valid2 = 1'b1; else req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_valid2 = 1'b0;
        cyc = 1;
        while (cyc < 20 && !(sel ? resp_valid2 : resp_valid)) begin
            check({tag, "/wait_ready"}, {31'd0, sel ? req_ready2 : req_ready}, 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "/latency"}, cyc, exp_lat);
        rd = sel ? resp_rdata2 : resp_rdata;
        er = sel ? resp_error2 : resp_error;
        check({tag, "/rdata"}, rd, exp_data);
        check({tag, "/error"}, {31'd0, er}, {31'd0, exp_err});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "/hold_valid"}, {31'd0, resp_valid}, 32'd1);
            check({tag, "/hold_rdata"}, resp_rdata, exp_data);
            check({tag, "/hold_error"}, {31'd0, resp_error}, {31'd0, exp_err});
            check({tag, "/hold_ready"}, {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "/done"}, {31'd0, sel ? resp_valid2 : resp_valid}, 32'd0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0; req_write = 1'b0;
        req_size = 2'b00; req_unsigned = 1'b0; req_addr = 9'h000;
        req_wdata = 32'h0000_0000; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",  {31'd0, req_ready},  32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata",      resp_rdata,          32'h0);
        check("rst_error",      {31'd0, resp_error}, 32'd0);
        check("rst_ready2",     {31'd0, req_ready2}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        do_req(0, 1, 2'b00, 0, 12'h010, 32'hDEADBEEF, 3, 32'h0, 0, 0, "st_w_deadbeef");
        do_req(0, 0, 2'b00, 0, 12'h010, 32'h0,        3, 32'hDEADBEEF, 0, 0, "ld_w_deadbeef");
        do_req(0, 1, 2'b00, 0, 12'h010, 32'h11223344, 3, 32'h0, 0, 0, "st_w_11223344");
        do_req(0, 1, 2'b11, 0, 12'h013, 32'hFFFFFF5A, 3, 32'h0, 0, 0, "st_b_5a");
        do_req(0, 0, 2'b00, 0, 12'h010, 32'h0,        3, 32'h5A223344, 0, 0, "ld_after_b");
        do_req(0, 1, 2'b10, 0, 12'h012, 32'h7777BEEF, 3, 32'h0, 0, 0, "st_h_beef");
        do_req(0, 0, 2'b00, 1, 12'h010, 32'h0,        3, 32'hBEEF3344, 0, 0, "ld_after_h");

        do_req(0, 1, 2'b00, 0, 12'h020, 32'h80FF7F01, 3, 32'h0, 0, 0, "st_w_80ff7f01");
        do_req(0, 0, 2'b11, 0, 12'h021, 32'h0, 3, 32'h0000007F, 0, 0, "ld_bs_021");
        do_req(0, 0, 2'b11, 0, 12'h022, 32'h0, 3, 32'hFFFFFFFF, 0, 0, "ld_bs_022");
        do_req(0, 0, 2'b11, 1, 12'h022, 32'h0, 3, 32'h000000FF, 0, 0, "ld_bu_022");
        do_req(0, 0, 2'b10, 1, 12'h022, 32'h0, 3, 32'h000080FF, 0, 0, "ld_hu_022");
        do_req(0, 0, 2'b10, 0, 12'h022, 32'h0, 3, 32'hFFFF80FF, 0, 0, "ld_hs_022");
        do_req(0, 0, 2'b10, 0, 12'h020, 32'h0, 3, 32'h00007F01, 0, 0, "ld_hs_020");

        do_req(0, 1, 2'b10, 0, 12'h011, 32'h00001234, 3, 32'h0, 1, 0, "st_h_misalign");
        do_req(0, 0, 2'b00, 0, 12'h010, 32'h0, 3, 32'hBEEF3344, 0, 0, "ld_unchanged");
        do_req(0, 0, 2'b00, 0, 12'h202, 32'h0, 3, 32'h0, 1, 0, "ld_w_misalign");
        do_req(0, 0, 2'b01, 0, 12'h010, 32'h0, 3, 32'h0, 1, 0, "ld_reserved");

        do_req(0, 1, 2'b00, 0, 12'h040, 32'h00000000, 3, 32'h0, 0, 0, "st_w_zero40");
        do_req(0, 0, 2'b00, 0, 12'h020, 32'h0, 3, 32'h80FF7F01, 0, 5, "ld_hold");

        // Payload changes while the store is in flight must not leak into it.
        req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 9'h030; req_wdata = 32'h12345678; req_valid = 1'b1;
        @(posedge clk); #1;
        req_addr = 9'h040; req_wdata = 32'hFFFFFFFF; req_size = 2'b11;
        check("tog_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 2;
        while (cyc < 20 && !resp_valid) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("tog_latency", cyc, 3);
        check("tog_error", {31'd0, resp_error}, 32'd0);
        @(posedge clk); #1;
        do_req(0, 0, 2'b00, 0, 12'h030, 32'h0, 3, 32'h12345678, 0, 0, "ld_tog_030");
        do_req(0, 0, 2'b00, 0, 12'h040, 32'h0, 3, 32'h00000000, 0, 0, "ld_tog_040");

        // Reset in WAIT discards the pending store.
        req_write = 1'b1; req_size = 2'b00; req_addr = 9'h040;
        req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_req_ready",  {31'd0, req_ready},  32'd1);
        check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("abort_rdata",      resp_rdata,          32'h0);
        check("abort_error",      {31'd0, resp_error}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_req(0, 0, 2'b00, 0, 12'h040, 32'h0, 3, 32'h00000000, 0, 0, "ld_after_abort");

        do_req(1, 1, 2'b00, 0, 12'h0FC, 32'hA5A5A5A5, 1, 32'h0, 0, 0, "d64_st_last");
        do_req(1, 0, 2'b00, 0, 12'h0FC, 32'h0, 1, 32'hA5A5A5A5, 0, 0, "d64_ld_last");
        do_req(1, 0, 2'b00, 0, 12'h100, 32'h0, 1, 32'h0, 1, 0, "d64_ld_range");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
